sensor_avg_bank: RTL and testbench

//  N-channel exponential moving-average engine for eBike sensor conditioning (current, torque, spares).
//  Per channel: event source (external trigger or shared periodic timer), programmable weight 2^-k, reseed.

---
 rtl/sensor_avg_bank.sv | 139 +++++++++++++
 tb/tb_sensor_avg_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_avg_bank.sv
// sensor_avg_bank: N-channel exponential moving-average engine.
// Buffered per-channel events, round-robin serviced on one shared datapath.
module sensor_avg_bank #(
  parameter int NCH      = 4,
  parameter int W        = 12,
  parameter int TMR_W    = 22,
  parameter int FAST_SIM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] smpl_in,
  input  logic [NCH-1:0]   trig,
  input  logic [NCH-1:0]   use_tmr,
  input  logic [NCH-1:0]   reseed,
  input  logic [NCH*3-1:0] k_sel,
  input  logic             clr_ovr,
  output logic [NCH*W-1:0] avg_out,
  output logic [NCH-1:0]   avg_vld,
  output logic             tmr_tick,
  output logic [NCH-1:0]   ovr_err
);

  localparam int AW = W + 7;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [TMR_W-1:0] r_tmr;
  logic [W-1:0]     r_hold [NCH];
  logic [AW-1:0]    r_acc  [NCH];
  logic [2:0]       r_k_act [NCH];
  logic [W-1:0]     r_avg  [NCH];
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   r_kind;
  logic [NCH-1:0]   r_ovr;
  logic [NCH-1:0]   r_vld;
  logic [IW-1:0]    r_rr;

  logic             w_tick;
  logic [NCH-1:0]   w_evt;
  logic             w_svc_vld;
  logic [IW-1:0]    w_svc_idx;
  logic [NCH-1:0]   w_svc_oh;
  logic [2:0]       w_k;
  logic [AW-1:0]    w_acc_old;
  logic [AW-1:0]    w_hold_ext;
  logic [AW-1:0]    w_acc_new;
  logic [W-1:0]     w_avg_new;
  logic [IW-1:0]    w_rr_nxt;

  // Shared sample timer decode; fast mode ticks on the low 16 bits only
  always_comb begin
    w_tick = 1'b0;
    if (FAST_SIM != 0) w_tick = &r_tmr[15:0];
    else               w_tick = &r_tmr;
  end

  // Per-channel event: reseed, or the selected trigger source
  always_comb begin
    w_evt = reseed
          | (use_tmr & {NCH{w_tick}})
          | (~use_tmr & trig);
  end

  // Round-robin pick: first pending channel at or after r_rr
  always_comb begin
    int v;
    w_svc_vld = 1'b0;
    w_svc_idx = '0;
    v = 0;
    for (int off = 0; off < NCH; off++) begin
      v = (int'(r_rr) + off) % NCH;
      if (!w_svc_vld && r_pend[v]) begin
        w_svc_vld = 1'b1;
        w_svc_idx = IW'(v);
      end
    end
  end

  // Shared EMA datapath for the channel being serviced
  always_comb begin
    w_svc_oh   = w_svc_vld ? (NCH'(1) << w_svc_idx) : '0;
    w_k        = k_sel[int'(w_svc_idx)*3 +: 3];
    w_acc_old  = r_acc[w_svc_idx];
    w_hold_ext = AW'(r_hold[w_svc_idx]);
    if (r_kind[w_svc_idx])
      w_acc_new = w_hold_ext << w_k;
    else
      w_acc_new = w_acc_old - (w_acc_old >> w_k) + w_hold_ext;
    w_avg_new = W'(w_acc_new >> w_k);
    w_rr_nxt  = (w_svc_idx == IW'(NCH - 1)) ? '0 : w_svc_idx + 1'b1;
  end

  // Timer, event capture, arbitration state and channel update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr  <= '0;
      r_pend <= '0;
      r_kind <= '0;
      r_ovr  <= '0;
      r_vld  <= '0;
      r_rr   <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_hold[i]  <= '0;
        r_acc[i]   <= '0;
        r_k_act[i] <= '0;
        r_avg[i]   <= '0;
      end
    end else begin
      r_tmr <= w_tick ? '0 : r_tmr + 1'b1;
      r_vld <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (w_evt[i]) begin
          r_hold[i] <= smpl_in[i*W +: W];
          r_kind[i] <= reseed[i];
        end
      end
      if (w_svc_vld) begin
        r_acc[w_svc_idx]   <= w_acc_new;
        r_k_act[w_svc_idx] <= w_k;
        r_avg[w_svc_idx]   <= w_avg_new;
        r_vld[w_svc_idx]   <= 1'b1;
        r_rr               <= w_rr_nxt;
      end
      r_pend <= w_evt | (r_pend & ~w_svc_oh);
      r_ovr  <= (r_ovr & ~{NCH{clr_ovr}})
              | (w_evt & r_pend & ~w_svc_oh);
    end
  end

  // Pack registered averages onto the output bus
  always_comb begin
    avg_out = '0;
    for (int i = 0; i < NCH; i++) avg_out[i*W +: W] = r_avg[i];
  end

  assign avg_vld  = r_vld;
  assign tmr_tick = w_tick;
  assign ovr_err  = r_ovr;

endmodule

// File: tb/tb_sensor_avg_bank.sv
// tb_sensor_avg_bank: directed checks of the averaging bank.
// FAST_SIM=1 so the shared timer ticks every 65536 clk.
module tb_sensor_avg_bank;

  logic        clk;
  logic        rst;
  logic [47:0] smpl_in;
  logic [3:0]  trig;
  logic [3:0]  use_tmr;
  logic [3:0]  reseed;
  logic [11:0] k_sel;
  logic        clr_ovr;
  logic [47:0] avg_out;
  logic [3:0]  avg_vld;
  logic        tmr_tick;
  logic [3:0]  ovr_err;

  int total;
  int bad;

  sensor_avg_bank #(
    .NCH(4), .W(12), .TMR_W(22), .FAST_SIM(1)
  ) dut (
    .clk(clk), .rst(rst), .smpl_in(smpl_in), .trig(trig),
    .use_tmr(use_tmr), .reseed(reseed), .k_sel(k_sel),
    .clr_ovr(clr_ovr), .avg_out(avg_out), .avg_vld(avg_vld),
    .tmr_tick(tmr_tick), .ovr_err(ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if (avg_out !== 48'h0) begin
      bad++;
      $display("FAIL rst_avg got=%h want=0", avg_out);
    end
    total++;
    if (avg_vld !== 4'h0 || tmr_tick !== 1'b0 || ovr_err !== 4'h0) begin
      bad++;
      $display("FAIL rst_flags got vld=%b tick=%b ovr=%b want 0",
               avg_vld, tmr_tick, ovr_err);
    end
  endtask

  task automatic test_timer();
    int tick_n, tick_at, vld_n, vld_at;
    tick_n = 0; tick_at = -1; vld_n = 0; vld_at = -1;
    use_tmr = 4'b0100;
    smpl_in[24 +: 12] = 12'h0AA;
    for (int i = 0; i <= 65540; i++) begin
      if (tmr_tick === 1'b1) begin
        tick_n++;
        if (tick_at < 0) tick_at = i;
      end
      if (avg_vld[2] === 1'b1) begin
        vld_n++;
        if (vld_at < 0) vld_at = i;
      end
      trig[2] = i[0];
      step();
    end
    trig = 4'h0;
    use_tmr = 4'h0;
    total++;
    if (tick_n != 1) begin
      bad++;
      $display("FAIL tmr_tick_count got=%0d want=1", tick_n);
    end
    total++;
    if (tick_at != 65535) begin
      bad++;
      $display("FAIL tmr_tick_cycle got=%0d want=65535", tick_at);
    end
    total++;
    if (vld_n != 1) begin
      bad++;
      $display("FAIL tmr_ch2_updates got=%0d want=1", vld_n);
    end
    total++;
    if (vld_at != 65537) begin
      bad++;
      $display("FAIL tmr_ch2_cycle got=%0d want=65537", vld_at);
    end
    total++;
    if (avg_out[35:24] !== 12'h0AA || ovr_err !== 4'h0) begin
      bad++;
      $display("FAIL tmr_ch2_val got avg=%h ovr=%b want 0aa/0",
               avg_out[35:24], ovr_err);
    end
  endtask

  task automatic test_reseed();
    k_sel[2:0] = 3'd2;
    smpl_in[11:0] = 12'h400;
    reseed = 4'b0001;
    step();
    reseed = 4'h0;
    total++;
    if (avg_vld !== 4'h0) begin
      bad++;
      $display("FAIL reseed_early got=%b want=0000", avg_vld);
    end
    step();
    total++;
    if (avg_vld !== 4'b0001 || avg_out[11:0] !== 12'h400) begin
      bad++;
      $display("FAIL reseed_out got vld=%b avg=%h want 0001/400",
               avg_vld, avg_out[11:0]);
    end
    step();
    total++;
    if (avg_vld !== 4'h0) begin
      bad++;
      $display("FAIL reseed_pulse got=%b want=0000", avg_vld);
    end
  endtask

  task automatic test_ema();
    logic [11:0] exp_v [3];
    exp_v[0] = 12'h200;
    exp_v[1] = 12'h380;
    exp_v[2] = 12'h4A0;
    k_sel[2:0] = 3'd2;
    smpl_in[11:0] = 12'h000;
    reseed = 4'b0001;
    step();
    reseed = 4'h0;
    step();
    step();
    for (int j = 0; j < 3; j++) begin
      smpl_in[11:0] = 12'h800;
      trig = 4'b0001;
      step();
      trig = 4'h0;
      step();
      total++;
      if (avg_vld !== 4'b0001 || avg_out[11:0] !== exp_v[j]) begin
        bad++;
        $display("FAIL ema_%0d got vld=%b avg=%h want 0001/%h",
                 j, avg_vld, avg_out[11:0], exp_v[j]);
      end
      for (int s = 0; s < 6; s++) step();
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    step();
    rst = 1'b0;
    k_sel = 12'h000;
    smpl_in = {12'h444, 12'h333, 12'h222, 12'h111};
    trig = 4'hF;
    step();
    trig = 4'h0;
    for (int j = 0; j < 4; j++) begin
      step();
      total++;
      if (avg_vld !== (4'b0001 << j) ||
          avg_out[j*12 +: 12] !== 12'(12'h111 * (j + 1))) begin
        bad++;
        $display("FAIL b2b_ch%0d got vld=%b avg=%h want %b/%h",
                 j, avg_vld, avg_out[j*12 +: 12], 4'b0001 << j,
                 12'(12'h111 * (j + 1)));
      end
    end
    total++;
    if (ovr_err !== 4'h0) begin
      bad++;
      $display("FAIL b2b_ovr got=%b want=0000", ovr_err);
    end
  endtask

  task automatic test_overrun();
    int upd;
    smpl_in = {12'h555, 12'h666, 12'h777, 12'h888};
    trig = 4'hF;
    step();
    smpl_in[36 +: 12] = 12'hABC;
    trig = 4'b1000;
    step();
    trig = 4'h0;
    total++;
    if (ovr_err !== 4'b1000) begin
      bad++;
      $display("FAIL ovr_set got=%b want=1000", ovr_err);
    end
    upd = 0;
    for (int j = 0; j < 5; j++) begin
      if (avg_vld[3] === 1'b1) upd++;
      step();
    end
    total++;
    if (upd != 1 || avg_out[47:36] !== 12'hABC) begin
      bad++;
      $display("FAIL ovr_ch3 got upd=%0d avg=%h want 1/abc",
               upd, avg_out[47:36]);
    end
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    total++;
    if (ovr_err !== 4'h0) begin
      bad++;
      $display("FAIL ovr_clr got=%b want=0000", ovr_err);
    end
  endtask

  task automatic test_mid_reset();
    trig = 4'hF;
    step();
    trig = 4'h0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (avg_out !== 48'h0 || avg_vld !== 4'h0 || ovr_err !== 4'h0) begin
      bad++;
      $display("FAIL mrst_out got avg=%h vld=%b ovr=%b want 0",
               avg_out, avg_vld, ovr_err);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      total++;
      if (avg_vld !== 4'h0) begin
        bad++;
        $display("FAIL mrst_idle_%0d got=%b want=0000", j, avg_vld);
      end
    end
    smpl_in[12 +: 12] = 12'h123;
    trig = 4'b0010;
    step();
    trig = 4'h0;
    step();
    total++;
    if (avg_vld !== 4'b0010 || avg_out[23:12] !== 12'h123) begin
      bad++;
      $display("FAIL mrst_new got vld=%b avg=%h want 0010/123",
               avg_vld, avg_out[23:12]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    smpl_in = '0;
    trig = '0;
    use_tmr = '0;
    reseed = '0;
    k_sel = '0;
    clr_ovr = 1'b0;
    test_reset();
    test_timer();
    test_reseed();
    test_ema();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
